// File: rtl/burst_bus_arbiter_pkg.sv
// Shared types and constants for the burst-bus arbiter and its round-robin picker.
package burst_bus_arbiter_pkg;

  typedef enum bit [1:0] {ARB_IDLE, ARB_WRITE, ARB_READ} burst_arb_state_e;

  localparam logic BURST_CMD_READ  = 1'b0;
  localparam logic BURST_CMD_WRITE = 1'b1;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_grant, wrapping modulo N.
module rr_priority_pick
  import burst_bus_arbiter_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_grant) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/burst_bus_arbiter.sv
// N-to-1 burst-bus arbiter: round-robin grant held for one full burst, read beats routed to the owner.
module burst_bus_arbiter
  import burst_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 21,
  parameter int unsigned BURST_BEATS = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_MASTERS-1:0]                       m_cmd_en,
  input  logic [NUM_MASTERS-1:0]                       m_cmd,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]       m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]       m_wr_data,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]     m_data_mask,
  output logic [NUM_MASTERS-1:0]                       m_ready,
  output logic [DATA_WIDTH-1:0]                        m_rd_data,
  output logic [NUM_MASTERS-1:0]                       m_rd_data_valid,
  output logic                                         s_cmd_en,
  output logic                                         s_cmd,
  output logic [ADDR_WIDTH-1:0]                        s_addr,
  output logic [DATA_WIDTH-1:0]                        s_wr_data,
  output logic [DATA_WIDTH/8-1:0]                      s_data_mask,
  input  logic                                         s_ready,
  input  logic [DATA_WIDTH-1:0]                        s_rd_data,
  input  logic                                         s_rd_data_valid,
  output logic                                         busy
);

  localparam int unsigned OW = idx_width(NUM_MASTERS);
  localparam int unsigned BW = $clog2(BURST_BEATS);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BURST_BEATS - 1);
  localparam logic [OW-1:0] LAST_MASTER = OW'(NUM_MASTERS - 1);

  if (BURST_BEATS < 2 || (BURST_BEATS & (BURST_BEATS - 1)) != 0) begin : g_bad_beats
    $error("burst_bus_arbiter: BURST_BEATS must be a power of two and at least 2");
  end
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
    $error("burst_bus_arbiter: NUM_MASTERS must be in 2..8");
  end

  burst_arb_state_e state_q;
  logic [OW-1:0]    owner_q;
  logic [OW-1:0]    last_grant_q;
  logic [BW-1:0]    beat_cnt_q;

  logic [NUM_MASTERS-1:0] pick_grant;
  logic [OW-1:0]          pick_idx;
  logic                   issue;
  logic [OW-1:0]          sel;

  rr_priority_pick #(
    .N  (NUM_MASTERS),
    .IW (OW)
  ) u_pick (
    .req        (m_cmd_en),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .grant_idx  (pick_idx)
  );

  // The issue cycle is combinational, so the bus mux follows the winner before owner_q is loaded.
  always_comb begin
    issue           = (state_q == ARB_IDLE) && s_ready && (|m_cmd_en);
    sel             = issue ? pick_idx : owner_q;
    s_cmd_en        = issue;
    s_cmd           = m_cmd[sel];
    s_addr          = m_addr[sel];
    s_wr_data       = m_wr_data[sel];
    s_data_mask     = m_data_mask[sel];
    m_ready         = issue ? pick_grant : '0;
    m_rd_data       = s_rd_data;
    m_rd_data_valid = '0;
    if (state_q == ARB_READ) begin
      m_rd_data_valid[owner_q] = s_rd_data_valid;
    end
    busy            = (state_q != ARB_IDLE);
  end

  // Writes count cycles from the issue beat; reads count received beats, so they start from zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      last_grant_q <= LAST_MASTER;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (issue) begin
            owner_q      <= pick_idx;
            last_grant_q <= pick_idx;
            if (m_cmd[pick_idx] == BURST_CMD_WRITE) begin
              state_q    <= ARB_WRITE;
              beat_cnt_q <= BW'(1);
            end else begin
              state_q    <= ARB_READ;
              beat_cnt_q <= '0;
            end
          end
        end
        ARB_WRITE: begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_READ: begin
          if (s_rd_data_valid) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) begin
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Scoreboard bench for burst_bus_arbiter with three masters and four-beat bursts.
module tb_burst_bus_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 21;
  localparam int unsigned BB = 4;
  localparam int unsigned MW = DW / 8;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N-1:0]           m_cmd_en;
  logic [N-1:0]           m_cmd;
  logic [N-1:0][AW-1:0]   m_addr;
  logic [N-1:0][DW-1:0]   m_wr_data;
  logic [N-1:0][MW-1:0]   m_data_mask;
  logic [N-1:0]           m_ready;
  logic [DW-1:0]          m_rd_data;
  logic [N-1:0]           m_rd_data_valid;
  logic                   s_cmd_en;
  logic                   s_cmd;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_wr_data;
  logic [MW-1:0]          s_data_mask;
  logic                   s_ready;
  logic [DW-1:0]          s_rd_data;
  logic                   s_rd_data_valid;
  logic                   busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0]  grant_q[$];
  logic [DW-1:0] beat_q[$];
  logic [MW-1:0] mask_q[$];

  int offs_a[4] = '{6, 7, 8, 9};
  int offs_b[4] = '{5, 7, 8, 12};

  always #5 clk = ~clk;

  burst_bus_arbiter #(
    .NUM_MASTERS (N),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BURST_BEATS (BB)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_cmd_en        (m_cmd_en),
    .m_cmd           (m_cmd),
    .m_addr          (m_addr),
    .m_wr_data       (m_wr_data),
    .m_data_mask     (m_data_mask),
    .m_ready         (m_ready),
    .m_rd_data       (m_rd_data),
    .m_rd_data_valid (m_rd_data_valid),
    .s_cmd_en        (s_cmd_en),
    .s_cmd           (s_cmd),
    .s_addr          (s_addr),
    .s_wr_data       (s_wr_data),
    .s_data_mask     (s_data_mask),
    .s_ready         (s_ready),
    .s_rd_data       (s_rd_data),
    .s_rd_data_valid (s_rd_data_valid),
    .busy            (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write burst; returns after sampling beat abort_at when abort_at < BB, leaving reset_n low.
  task automatic do_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] base,
                          input int abort_at);
    s_ready        = 1'b1;
    m_cmd_en[m]    = 1'b1;
    m_cmd[m]       = 1'b1;
    m_addr[m]      = addr;
    m_wr_data[m]   = base;
    m_data_mask[m] = 8'(base);
    for (int b = 0; b < int'(BB); b++) begin
      beat_q.push_back(base + 64'(b));
      mask_q.push_back(8'(base + 64'(b)));
    end
    @(negedge clk);
    check_val("wr_ack", 64'(m_ready), 64'(grant_q.pop_front()));
    check_val("wr_cmd_en", 64'(s_cmd_en), 64'd1);
    check_val("wr_cmd", 64'(s_cmd), 64'd1);
    check_val("wr_addr", 64'(s_addr), 64'(addr));
    check_val("wr_beat0", s_wr_data, beat_q.pop_front());
    check_val("wr_mask0", 64'(s_data_mask), 64'(mask_q.pop_front()));
    check_val("wr_busy0", 64'(busy), 64'd0);
    for (int b = 1; b < int'(BB); b++) begin
      next_cycle();
      m_cmd_en[m]    = 1'b0;
      s_ready        = 1'b0;
      m_wr_data[m]   = base + 64'(b);
      m_data_mask[m] = 8'(base + 64'(b));
      @(negedge clk);
      check_val("wr_beat", s_wr_data, beat_q.pop_front());
      check_val("wr_mask", 64'(s_data_mask), 64'(mask_q.pop_front()));
      check_val("wr_busy", 64'(busy), 64'd1);
      check_val("wr_no_ack", 64'(m_ready), 64'd0);
      check_val("wr_no_issue", 64'(s_cmd_en), 64'd0);
      if (b == abort_at) begin
        reset_n = 1'b0;
        beat_q.delete();
        mask_q.delete();
        return;
      end
    end
  endtask

  task automatic do_read(input int m, input logic [AW-1:0] addr, input int offs[4], input bit keep);
    bit            v;
    logic [DW-1:0] d;
    s_ready     = 1'b1;
    m_cmd_en[m] = 1'b1;
    m_cmd[m]    = 1'b0;
    m_addr[m]   = addr;
    @(negedge clk);
    check_val("rd_ack", 64'(m_ready), 64'(grant_q.pop_front()));
    check_val("rd_cmd_en", 64'(s_cmd_en), 64'd1);
    check_val("rd_cmd", 64'(s_cmd), 64'd0);
    check_val("rd_addr", 64'(s_addr), 64'(addr));
    for (int k = 1; k <= offs[3]; k++) begin
      next_cycle();
      if (!keep) m_cmd_en[m] = 1'b0;
      s_ready = 1'b0;
      v = 1'b0;
      for (int j = 0; j < 4; j++) if (offs[j] == k) v = 1'b1;
      d = {$urandom(), $urandom()};
      s_rd_data_valid = v;
      s_rd_data       = d;
      if (v) beat_q.push_back(d);
      @(negedge clk);
      check_val("rd_valid", 64'(m_rd_data_valid), v ? (64'd1 << m) : 64'd0);
      if (v) check_val("rd_data", m_rd_data, beat_q.pop_front());
      check_val("rd_busy", 64'(busy), 64'd1);
      check_val("rd_no_ack", 64'(m_ready), 64'd0);
    end
    next_cycle();
    s_rd_data_valid = 1'b0;
    @(negedge clk);
    check_val("rd_done_busy", 64'(busy), 64'd0);
    check_val("rd_done_valid", 64'(m_rd_data_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n         = 1'b0;
    s_ready         = 1'b0;
    s_rd_data       = 64'h5A5A_0000_1234_0000;
    s_rd_data_valid = 1'b1;
    m_cmd_en        = '0;
    m_cmd           = '0;
    for (int i = 0; i < int'(N); i++) begin
      m_addr[i]      = AW'(21'h0AAAA + i);
      m_wr_data[i]   = 64'hD0 + 64'(i);
      m_data_mask[i] = 8'h3C + 8'(i);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    check_val("rst_cmd_en", 64'(s_cmd_en), 64'd0);
    check_val("rst_ready", 64'(m_ready), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rd_valid", 64'(m_rd_data_valid), 64'd0);
    check_val("rst_addr_m0", 64'(s_addr), 64'h0AAAA);
    check_val("rst_wdata_m0", s_wr_data, 64'hD0);
    check_val("rst_mask_m0", 64'(s_data_mask), 64'h3C);
    check_val("rst_rd_data", m_rd_data, 64'h5A5A_0000_1234_0000);

    // Single write from master 1.
    next_cycle();
    reset_n         = 1'b1;
    s_rd_data_valid = 1'b0;
    grant_q.push_back(3'b010);
    do_write(1, 21'h00100, 64'hA0, BB);
    next_cycle();
    s_ready = 1'b1;
    @(negedge clk);
    check_val("wr_end_busy", 64'(busy), 64'd0);
    check_val("wr_end_idle", 64'(s_cmd_en), 64'd0);

    // Continuous reads from all masters after reset: order 0,1,2,0.
    next_cycle();
    reset_n = 1'b0;
    s_ready = 1'b0;
    next_cycle();
    reset_n  = 1'b1;
    m_cmd_en = '1;
    m_cmd    = '0;
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b010);
    grant_q.push_back(3'b100);
    grant_q.push_back(3'b001);
    do_read(0, 21'h00200, offs_a, 1'b1);
    next_cycle();
    do_read(1, 21'h00201, offs_a, 1'b1);
    next_cycle();
    do_read(2, 21'h00202, offs_a, 1'b1);
    next_cycle();
    do_read(0, 21'h00203, offs_a, 1'b0);
    m_cmd_en = '0;

    // Read with gaps between beats.
    next_cycle();
    grant_q.push_back(3'b010);
    do_read(1, 21'h00300, offs_b, 1'b0);

    // s_ready low blocks issue; rising s_ready acks in the same cycle.
    next_cycle();
    s_ready     = 1'b0;
    m_cmd_en[2] = 1'b1;
    m_cmd[2]    = 1'b1;
    m_addr[2]   = 21'h00400;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("nrdy_ack", 64'(m_ready), 64'd0);
      check_val("nrdy_cmd_en", 64'(s_cmd_en), 64'd0);
      next_cycle();
    end
    grant_q.push_back(3'b100);
    do_write(2, 21'h00400, 64'hC0, BB);

    // Reset during beat 2 of a write; trailing read-valid pulses are ignored.
    next_cycle();
    grant_q.push_back(3'b001);
    do_write(0, 21'h00500, 64'hE0, 2);
    next_cycle();
    reset_n         = 1'b1;
    s_rd_data_valid = 1'b1;
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_cmd_en", 64'(s_cmd_en), 64'd0);
    check_val("abort_ready", 64'(m_ready), 64'd0);
    check_val("abort_rd_valid", 64'(m_rd_data_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      s_rd_data_valid = (k != 1);
      @(negedge clk);
      check_val("abort_ignore_valid", 64'(m_rd_data_valid), 64'd0);
      check_val("abort_idle", 64'(busy), 64'd0);
    end

    // Masters 0 and 2 together after reset: 0 first, 2 right after the burst.
    next_cycle();
    s_rd_data_valid = 1'b0;
    m_cmd_en[2]     = 1'b1;
    m_cmd[2]        = 1'b1;
    m_addr[2]       = 21'h00602;
    m_wr_data[2]    = 64'hF0;
    m_data_mask[2]  = 8'hF0;
    grant_q.push_back(3'b001);
    grant_q.push_back(3'b100);
    do_write(0, 21'h00600, 64'hB0, BB);
    next_cycle();
    do_write(2, 21'h00602, 64'hF0, BB);
    next_cycle();
    s_ready = 1'b1;
    @(negedge clk);
    check_val("final_idle", 64'(busy), 64'd0);
    check_val("final_queue", 64'(grant_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
